// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter in front of a single-ported, combinationally read DataMem.
//   Port 0 (core) and port 1 (DMA/peripheral) compete for the memory. A port
//   that is granted is served in the same cycle its request is seen. Ties go
//   to the port that was not served last. A port may keep the grant by holding
//   mX_lock. While the other port waits, the lock is honoured for at most
//   MAX_LOCK extra cycles, and then the grant is forced over.
//
// Parameters
//   MAX_LOCK  max consecutive locked retentions while the other port waits
//   CNT_W     lock counter width, 2**CNT_W > MAX_LOCK
//
// Ports
//   clk, reset                      rising-edge clock, async active-low reset
//   mX_req/we/lock/addr/wdata       port X request, write strobe, lock, address, data
//   mX_ack, mX_rdata                port X served this cycle, read data
//   oMemAddr/Read/Write/WriteData   DataMem command (combinational from owner)
//   iMemReadData                    DataMem combinational read data
//   oGrant                          one-hot owner, 00 = idle
module mem_arbiter #(
  parameter int MAX_LOCK = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,

  output logic [31:0] oMemAddr,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [31:0] oMemWriteData,
  input  logic [31:0] iMemReadData,
  output logic [1:0]  oGrant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  state_e           state_q, state_d;
  logic             last_q, last_d;        // index of the port acked most recently
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic             own_req, own_lock, oth_req, force_sw;

  // Pick the single requester, or on a tie the port not served last.
  function automatic state_e pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1)  pick = last ? GNT0 : GNT1;
    else if (r0)   pick = GNT0;
    else if (r1)   pick = GNT1;
    else           pick = IDLE;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;   // port 0 wins the first tie after reset
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    own_req    = 1'b0;
    own_lock   = 1'b0;
    oth_req    = 1'b0;

    case (state_q)
      GNT0: begin
        own_req  = m0_req;
        own_lock = m0_lock;
        oth_req  = m1_req;
      end
      GNT1: begin
        own_req  = m1_req;
        own_lock = m1_lock;
        oth_req  = m0_req;
      end
      default: ;
    endcase

    if (m0_ack)      last_d = 1'b0;
    else if (m1_ack) last_d = 1'b1;

    // The lock budget is spent once the counter reaches MAX_LOCK with the
    // other port still waiting; this edge hands the grant over regardless.
    force_sw = oth_req && (lock_cnt_q == LOCK_MAX);

    // A cycle without an owner ack leaves last_d == last_q, so arbitrating
    // with last_d covers IDLE, dropped requests and unlocked acks alike.
    if (state_q != IDLE && own_req && own_lock && !force_sw) state_d = state_q;
    else                                                   state_d = pick(m0_req, m1_req, last_d);

    if (state_d != state_q || state_d == IDLE || !oth_req)
      lock_cnt_d = '0;
    else if (own_req && own_lock && lock_cnt_q != LOCK_MAX)
      lock_cnt_d = lock_cnt_q + 1'b1;
  end

  // Output logic: the owner's command passes straight through to DataMem
  always_comb begin
    oGrant        = 2'b00;
    oMemAddr      = '0;
    oMemWriteData = '0;
    oMemRead      = 1'b0;
    oMemWrite     = 1'b0;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_rdata      = '0;
    m1_rdata      = '0;

    case (state_q)
      GNT0: begin
        oGrant        = 2'b01;
        oMemAddr      = m0_addr;
        oMemWriteData = m0_wdata;
        oMemWrite     = m0_req & m0_we;
        oMemRead      = m0_req & ~m0_we;
        m0_ack        = m0_req;
        m0_rdata      = iMemReadData;
      end
      GNT1: begin
        oGrant        = 2'b10;
        oMemAddr      = m1_addr;
        oMemWriteData = m1_wdata;
        oMemWrite     = m1_req & m1_we;
        oMemRead      = m1_req & ~m1_we;
        m1_ack        = m1_req;
        m1_rdata      = iMemReadData;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter: a DataMem array with combinational read, a
//   transaction-level model of who owns the memory, a per-cycle comparison
//   of every DUT output against that model, and directed scenarios with
//   hand-computed expectations.
module tb_mem_arbiter;

  localparam int MAX_LOCK = 16;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack;
  logic [31:0] oMemAddr, oMemWriteData, iMemReadData;
  logic        oMemRead, oMemWrite;
  logic [1:0]  oGrant;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.MAX_LOCK(MAX_LOCK), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .oMemAddr(oMemAddr), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oMemWriteData(oMemWriteData), .iMemReadData(iMemReadData), .oGrant(oGrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMem: word addressed, combinational read, write on the rising edge
  assign iMemReadData = mem[oMemAddr[9:2]];
  always @(posedge clk) if (oMemWrite) mem[oMemAddr[9:2]] <= oMemWriteData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: owner (-1 idle, 0, 1), port served last, and how many locked
  // retentions the owner has taken while the other port waited.
  int m_owner  = -1;
  int m_last   = 1;
  int m_streak = 0;

  function automatic void model_next(input int own, input int last, input int streak,
                                     input logic [1:0] r, input logic [1:0] l,
                                     output int n_own, output int n_last, output int n_streak);
    logic mine, theirs, mlk;
    mine   = (own == 0) ? r[0] : r[1];
    theirs = (own == 0) ? r[1] : r[0];
    mlk    = (own == 0) ? l[0] : l[1];
    n_own    = own;
    n_last   = last;
    n_streak = 0;
    if (own >= 0 && mine) begin
      n_last = own;
      if (mlk && !(theirs && streak == MAX_LOCK)) begin
        n_streak = theirs ? ((streak < MAX_LOCK) ? streak + 1 : MAX_LOCK) : 0;
        return;
      end
    end
    if (r == 2'b11)   n_own = 1 - n_last;
    else if (r[0])    n_own = 0;
    else if (r[1])    n_own = 1;
    else              n_own = -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner  <= -1;
      m_last   <= 1;
      m_streak <= 0;
    end else begin
      int a, b, c;
      model_next(m_owner, m_last, m_streak, {m1_req, m0_req}, {m1_lock, m0_lock}, a, b, c);
      m_owner  <= a;
      m_last   <= b;
      m_streak <= c;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic        e_rd, e_wr, e_a0, e_a1;
    logic [1:0]  e_g;
    e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
    e_rd = 1'b0; e_wr = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0; e_g = 2'b00;
    if (m_owner == 0) begin
      e_g = 2'b01; e_addr = m0_addr; e_wdata = m0_wdata;
      e_wr = m0_req & m0_we; e_rd = m0_req & ~m0_we; e_a0 = m0_req;
      e_rd0 = mem[m0_addr[9:2]];
    end else if (m_owner == 1) begin
      e_g = 2'b10; e_addr = m1_addr; e_wdata = m1_wdata;
      e_wr = m1_req & m1_we; e_rd = m1_req & ~m1_we; e_a1 = m1_req;
      e_rd1 = mem[m1_addr[9:2]];
    end
    chk("cmp_grant",  32'(oGrant),    32'(e_g));
    chk("cmp_addr",   oMemAddr,       e_addr);
    chk("cmp_wdata",  oMemWriteData,  e_wdata);
    chk("cmp_read",   32'(oMemRead),  32'(e_rd));
    chk("cmp_write",  32'(oMemWrite), 32'(e_wr));
    chk("cmp_ack0",   32'(m0_ack),    32'(e_a0));
    chk("cmp_ack1",   32'(m1_ack),    32'(e_a1));
    chk("cmp_rdata0", m0_rdata,       e_rd0);
    chk("cmp_rdata1", m1_rdata,       e_rd1);
    chk("cmp_onehot", 32'((oMemRead & oMemWrite) | (m0_ack & m1_ack)), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, prev, cur, alt_ok, run1, got0;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
    mem[4] = 32'hDEAD_BEEF;   // byte address 0x10
    mem[8] = 32'h1234_5678;   // byte address 0x20

    reset = 1'b0;
    idle_inputs();
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(oGrant), 32'd0);
    chk("rst_acks",  32'({m0_ack, m1_ack}), 32'd0);
    chk("rst_en",    32'({oMemRead, oMemWrite}), 32'd0);
    reset = 1'b1;

    // Single read from idle: acked one cycle after the request
    step(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk); chk("rd_idle_ack", 32'(m0_ack), 32'd0);
    step();
    @(negedge clk);
    chk("rd_grant", 32'(oGrant), 32'd1);
    chk("rd_ack",   32'(m0_ack), 32'd1);
    chk("rd_data",  m0_rdata,    32'hDEAD_BEEF);
    step(); m0_req = 1'b0;
    repeat (2) step();

    // Tie after reset: port 0 first, then port 1 with no idle cycle
    do_reset();
    step(); m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1; m1_addr = 32'h4;
    @(negedge clk); chk("tie_idle", 32'(oGrant), 32'd0);
    step();
    @(negedge clk);
    chk("tie_g0",   32'(oGrant), 32'd1);
    chk("tie_ack0", 32'(m0_ack), 32'd1);
    chk("tie_nak1", 32'(m1_ack), 32'd0);
    step(); m0_req = 1'b0;
    @(negedge clk);
    chk("tie_g1",   32'(oGrant), 32'd2);
    chk("tie_ack1", 32'(m1_ack), 32'd1);
    step(); m1_req = 1'b0;
    repeat (2) step();

    // Continuous contention, unlocked writes: strict alternation over 8 cycles
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h0000_A0A0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h0000_B1B1;
    step();
    n0 = 0; n1 = 0; prev = -1; alt_ok = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m0_ack) n0++;
      if (m1_ack) n1++;
      cur = m0_ack ? 0 : (m1_ack ? 1 : 2);
      if (cur == 2 || cur == prev) alt_ok = 0;
      prev = cur;
    end
    chk("cont_acks0", 32'(n0), 32'd4);
    chk("cont_acks1", 32'(n1), 32'd4);
    chk("cont_alt",   32'(alt_ok), 32'd1);
    step(); idle_inputs();
    repeat (3) step();
    chk("cont_mem0", mem[16], 32'h0000_A0A0);
    chk("cont_mem1", mem[17], 32'h0000_B1B1);

    // Lock starvation bound: port 1 keeps the grant MAX_LOCK+1 cycles
    step(); m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    step(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hC;
    run1 = 0; got0 = 0;
    for (int i = 0; i < 40 && got0 == 0; i++) begin
      @(negedge clk);
      if (m1_ack)      run1++;
      else if (m0_ack) got0 = 1;
    end
    chk("lock_run",      32'(run1), 32'd17);
    chk("lock_handover", 32'(got0), 32'd1);
    step(); idle_inputs();
    repeat (3) step();

    // Locked owner without contention keeps the grant; dropping req re-arbitrates
    step(); m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    repeat (3) step();
    @(negedge clk); chk("lock_hold", 32'(oGrant), 32'd1);
    step(); m0_req = 1'b0; m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;
    @(negedge clk);
    chk("drop_noacc", 32'({oMemRead, oMemWrite}), 32'd0);
    chk("drop_noack", 32'({m0_ack, m1_ack}), 32'd0);
    step();
    @(negedge clk); chk("drop_regrant", 32'(oGrant), 32'd2);
    step(); idle_inputs();
    repeat (2) step();

    // Reset asserted in the middle of a port 1 write cycle
    step(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55;
    step();
    chk("wr_active", 32'(oMemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstwr_we",    32'(oMemWrite), 32'd0);
    chk("rstwr_grant", 32'(oGrant),    32'd0);
    chk("rstwr_ack",   32'(m1_ack),    32'd0);
    idle_inputs();
    step();
    chk("rstwr_mem", mem[8], 32'h1234_5678);
    @(negedge clk); reset = 1'b1;

    // Isolation: port 1 inputs wiggle while port 0 owns the memory
    step(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step();
    for (int i = 0; i < 4; i++) begin
      m1_addr = 32'h100 + 32'(i) * 32'd4;
      m1_we   = ~m1_we;
      @(negedge clk);
      chk("iso_addr", oMemAddr,      32'h10);
      chk("iso_ack1", 32'(m1_ack),   32'd0);
      chk("iso_read", 32'(oMemRead), 32'd1);
      step();
    end
    idle_inputs();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_LOCK, default 16, which sets the maximum number of consecutive locked grant cycles while the other port is pending.
REQ-002 The block SHALL have parameter CNT_W, default 5, which sets the lock counter width; CNT_W SHALL satisfy 2^CNT_W > MAX_LOCK.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports as listed below.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 (core) access request
- m0_we  in  1  port 0 write when 1, read when 0
- m0_lock  in  1  port 0 requests grant retention after this access
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_ack  out  1  port 0 access performed this cycle
- m0_rdata  out  32  port 0 read data, valid when m0_ack=1
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1 (DMA/peripheral)
- oMemAddr  out  32  DataMem address
- oMemRead  out  1  DataMem read enable
- oMemWrite  out  1  DataMem write enable
- oMemWriteData  out  32  DataMem write data
- iMemReadData  in  32  DataMem combinational read data
- oGrant  out  2  one-hot current owner; 00 means idle

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, GNT0 and GNT1; oGrant SHALL be 00, 01 and 10 respectively.
REQ-005 Arbitration SHALL be evaluated at each rising edge, from IDLE, or from GNTx on a cycle with m{x}_ack=1 and the lock not held.
REQ-006 Arbitration SHALL select the single requesting port; if both ports request, it SHALL select the port not served last; if neither requests, it SHALL go to IDLE.
REQ-007 The last-served pointer SHALL update on every ack to the index of the acked port.
REQ-008 In GNTx, the memory outputs SHALL be driven combinationally: oMemAddr=m{x}_addr, oMemWriteData=m{x}_wdata, oMemWrite=m{x}_req&m{x}_we, oMemRead=m{x}_req&~m{x}_we.
REQ-009 In GNTx, m{x}_ack SHALL equal m{x}_req combinationally; the other port's ack SHALL be 0.
REQ-010 m{x}_rdata SHALL equal iMemReadData when port x is granted, and 0 otherwise.
REQ-011 In IDLE, all memory outputs, all acks and all rdata SHALL be 0.
REQ-012 Latency SHALL be as follows: a request raised in cycle N from IDLE is acked in cycle N+1; a requester SHALL hold req, we, addr and wdata stable until acked.
REQ-013 Back-to-back handover SHALL occur without an IDLE bubble: with both ports requesting continuously and no locks, the grants SHALL alternate 0,1,0,1 each cycle.
REQ-014 Lock: if m{x}_lock=1 and m{x}_ack=1, the block SHALL remain in GNTx.
REQ-015 lock_cnt SHALL increment on each locked ack while the other port requests; it SHALL saturate at MAX_LOCK.
REQ-016 When lock_cnt=MAX_LOCK and the other port requests, the next edge SHALL force a switch to the other port regardless of lock.
REQ-017 lock_cnt SHALL clear on any grant change, on entry to IDLE, and whenever the other port is not requesting.
REQ-018 If the owner in GNTx drops req (with or without lock), the next edge SHALL re-arbitrate per REQ-006; a cycle in GNTx with req=0 performs no memory access.
REQ-019 At most one of oMemRead and oMemWrite SHALL be 1 in any cycle, and at most one ack SHALL be 1.
REQ-020 Changes on the non-granted port's inputs SHALL have no effect on memory outputs.

Reset
REQ-021 Asserting reset (reset=0) SHALL immediately force IDLE, oGrant=00, lock_cnt=0, last-served=1 (so port 0 wins the first tie), and all acks and memory enables to 0.
REQ-022 If reset is asserted mid-access, the write in that cycle SHALL be suppressed, since oMemWrite drops asynchronously.
REQ-023 On release of reset, arbitration SHALL begin at the first rising edge with reset=1.

Verification
REQ-024 Single read: m0 read of addr 0x10 from IDLE, with DataMem holding 0xDEADBEEF -> oGrant=01 and m0_ack=1 one cycle later, with m0_rdata=0xDEADBEEF.
REQ-025 Tie after reset: m0 and m1 requesting in the same cycle -> m0 acked first, then m1 acked in the next cycle, with no idle cycle between.
REQ-026 Continuous contention: both ports requesting continuously for 8 cycles, unlocked -> 4 acks each, strictly alternating.
REQ-027 Lock starvation: m1 locked and requesting continuously, m0 requesting -> m1 acked for MAX_LOCK+1 consecutive cycles (first ack plus MAX_LOCK locked retentions), then m0 acked.
REQ-028 Reset during write: reset driven low mid-cycle while m1 writes 0x55 to 0x20 -> oMemWrite=0 immediately, memory location unchanged, oGrant=00.
REQ-029 Isolation: m1 toggling addr and we while m0 is granted -> oMemAddr tracks only m0_addr, and m1_ack remains 0.
